// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: ALU/LSU request channels, issue tap,
// and the register-file write port plus pending scoreboard.
interface rf_wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic [31:0] pending;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd,
        input  alu_ready, lsu_ready,
        input  rf_we, rf_a3, rf_wd3, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd,
        output alu_ready, lsu_ready,
        output rf_we, rf_a3, rf_wd3, pending
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: LSU over ALU with a starvation
// override, one-cycle registered write, and pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned CNT_W    = 4
) (
    input logic               clk,
    input logic               reset,
    rf_wb_arbiter_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [4:0]       a3_q, a3_d;
    logic [31:0]      wd3_q, wd3_d;
    logic [31:0]      pend_q, pend_d;

    logic             alu_gnt;
    logic             lsu_gnt;
    logic             starved;
    logic [4:0]       gnt_rd;
    logic [31:0]      gnt_data;

    assign starved = (cnt_q == CNT_MAX);

    // ALU only beats a valid LSU once it has lost MAX_WAIT times in a row
    assign alu_gnt = !reset && bus.alu_valid &&
                     (!bus.lsu_valid || starved);
    assign lsu_gnt = !reset && bus.lsu_valid &&
                     !(bus.alu_valid && starved);

    assign bus.alu_ready = alu_gnt;
    assign bus.lsu_ready = lsu_gnt;

    assign gnt_rd   = alu_gnt ? bus.alu_rd   : bus.lsu_rd;
    assign gnt_data = alu_gnt ? bus.alu_data : bus.lsu_data;

    always_comb begin
        cnt_d = cnt_q;
        if (!bus.alu_valid || alu_gnt) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        we_d  = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (alu_gnt || lsu_gnt) begin
            we_d  = (gnt_rd != 5'd0);
            a3_d  = gnt_rd;
            wd3_d = gnt_data;
        end
    end

    // Clear first so an issue to the same register on this edge wins
    always_comb begin
        pend_d = pend_q;
        if (we_d) begin
            pend_d[gnt_rd] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_rd != 5'd0) begin
            pend_d[bus.issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            we_q   <= 1'b0;
            a3_q   <= 5'd0;
            wd3_q  <= 32'd0;
            pend_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            we_q   <= we_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            pend_q <= pend_d;
        end
    end

    assign bus.rf_we   = we_q;
    assign bus.rf_a3   = a3_q;
    assign bus.rf_wd3  = wd3_q;
    assign bus.pending = pend_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and random bench for rf_wb_arbiter against a
// behavioural model of arbitration, write port and scoreboard.
module tb_rf_wb_arbiter;

    localparam int MAXW = 3;

    logic clk;
    logic reset;
    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.MAX_WAIT(MAXW), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    int          m_losses;
    bit          m_we;
    bit [4:0]    m_a3;
    bit [31:0]   m_wd3;
    bit          m_pend [32];
    bit          e_ag, e_lg;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        m_losses = 0;
        m_we     = 0;
        m_a3     = 0;
        m_wd3    = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".we"}, {31'd0, bus.rf_we}, {31'd0, m_we});
        if (m_we) begin
            chk({tag, ".a3"}, {27'd0, bus.rf_a3}, {27'd0, m_a3});
            chk({tag, ".wd3"}, bus.rf_wd3, m_wd3);
        end
        chk({tag, ".pend"}, bus.pending, pend_vec());
    endtask

    // one clock cycle: check registered outputs, drive, check ready
    task automatic step(input string tag,
                        input bit av, input bit [4:0] ard,
                        input bit [31:0] ad,
                        input bit lv, input bit [4:0] lrd,
                        input bit [31:0] ld,
                        input bit iv, input bit [4:0] ird);
        bit [4:0] rd;
        bit [31:0] d;
        @(negedge clk);
        check_regs(tag);
        bus.alu_valid   = av;
        bus.alu_rd      = ard;
        bus.alu_data    = ad;
        bus.lsu_valid   = lv;
        bus.lsu_rd      = lrd;
        bus.lsu_data    = ld;
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        #1;
        if (av && lv) begin
            e_ag = (m_losses >= MAXW);
            e_lg = !e_ag;
        end else begin
            e_ag = av;
            e_lg = lv;
        end
        chk({tag, ".ardy"}, {31'd0, bus.alu_ready}, {31'd0, e_ag});
        chk({tag, ".lrdy"}, {31'd0, bus.lsu_ready}, {31'd0, e_lg});
        if (e_ag || e_lg) begin
            rd    = e_ag ? ard : lrd;
            d     = e_ag ? ad : ld;
            m_we  = (rd != 0);
            m_a3  = rd;
            m_wd3 = d;
            if (m_we) m_pend[rd] = 0;
        end else begin
            m_we = 0;
        end
        if (iv && ird != 0) m_pend[ird] = 1;
        if (av && !e_ag) begin
            m_losses = (m_losses + 1 > MAXW) ? MAXW : m_losses + 1;
        end else begin
            m_losses = 0;
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    bit        ahold, lhold;
    bit        av, lv, iv;
    bit [4:0]  ard, lrd, ird;
    bit [31:0] ad, ld;

    initial begin
        model_reset();
        reset = 1'b1;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
        bus.issue_valid = 0; bus.issue_rd = 0;
        #2;
        chk("rst.we", {31'd0, bus.rf_we}, 32'd0);
        chk("rst.pend", bus.pending, 32'd0);
        bus.alu_valid = 1; bus.lsu_valid = 1;
        #1;
        chk("rst.ardy", {31'd0, bus.alu_ready}, 32'd0);
        chk("rst.lrdy", {31'd0, bus.lsu_ready}, 32'd0);
        bus.alu_valid = 0; bus.lsu_valid = 0;
        @(negedge clk);
        reset = 1'b0;

        idle("idle0");
        step("alu5", 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle("alu5a");
        chk("alu5.a3", {27'd0, bus.rf_a3}, 32'd5);
        chk("alu5.wd3", bus.rf_wd3, 32'hDEADBEEF);
        idle("alu5b");

        for (int i = 0; i < 9; i++)
            step("both", 1, 9, 32'h900 + i, 1, 7, 32'h700 + i, 0, 0);
        idle("both_end");

        step("iss12", 0, 0, 0, 0, 0, 0, 1, 12);
        idle("iss12a");
        chk("iss12.bit", {31'd0, bus.pending[12]}, 32'd1);
        idle("iss12b");
        step("lsu12", 0, 0, 0, 1, 12, 32'h12, 0, 0);
        idle("lsu12a");
        chk("lsu12.bit", {31'd0, bus.pending[12]}, 32'd0);
        chk("lsu12.a3", {27'd0, bus.rf_a3}, 32'd12);

        step("iss12c", 0, 0, 0, 0, 0, 0, 1, 12);
        step("race12", 1, 12, 32'hC, 0, 0, 0, 1, 12);
        idle("race12a");
        chk("race12.bit", {31'd0, bus.pending[12]}, 32'd1);
        step("lsu12c", 0, 0, 0, 1, 12, 32'h1, 0, 0);
        step("iss0", 0, 0, 0, 0, 0, 0, 1, 0);
        idle("iss0a");
        chk("iss0.pend", bus.pending, 32'd0);

        step("alu0", 1, 0, 32'h55, 0, 0, 0, 0, 0);
        idle("alu0a");

        step("preRst", 0, 0, 0, 1, 3, 32'hAB, 1, 20);
        @(negedge clk);
        check_regs("preRstR");
        reset = 1'b1;
        #1;
        chk("midRst.we", {31'd0, bus.rf_we}, 32'd0);
        chk("midRst.pend", bus.pending, 32'd0);
        chk("midRst.lrdy", {31'd0, bus.lsu_ready}, 32'd0);
        model_reset();
        bus.alu_valid = 0; bus.lsu_valid = 0; bus.issue_valid = 0;
        @(negedge clk);
        reset = 1'b0;

        ahold = 0; lhold = 0;
        for (int i = 0; i < 400; i++) begin
            if (!ahold) begin
                av  = ($urandom_range(0, 3) != 0);
                ard = 5'($urandom_range(0, 7));
                ad  = $urandom;
            end
            if (!lhold) begin
                lv  = ($urandom_range(0, 2) != 0);
                lrd = 5'($urandom_range(0, 7));
                ld  = $urandom;
            end
            iv  = $urandom_range(0, 1) == 1;
            ird = 5'($urandom_range(0, 7));
            step("rand", av, ard, ad, lv, lrd, ld, iv, ird);
            ahold = av && !e_ag;
            lhold = lv && !e_lg;
        end
        idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
